// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule types, constants and the round-constant table.
package aes_pkg;

   localparam int unsigned RIDX_W = 4;
   localparam int unsigned AES_NR = 10;
   localparam int unsigned AES_KW = 128;

   typedef logic [31:0] aes_word;

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      READY
   } state_t;

   // Round constant byte for rounds 1..10; other indices yield zero.
   function automatic logic [7:0] rcon(input logic [RIDX_W-1:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Table lookup indexed by the input byte.
   always_comb begin
      out_o = SBOX[in_i];
   end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands a cipher key into 11 round keys, one per
// clock, and serves them through a registered read port by round index.
module aes_key_expand #(
   parameter int unsigned NR = 10,
   parameter int unsigned KW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [KW-1:0] key_in,
   input  logic          key_load,
   input  logic          rd_en,
   input  logic [3:0]    rd_round,
   output logic [KW-1:0] rd_key,
   output logic          rd_valid,
   output logic          busy,
   output logic          key_ready
);

   import aes_pkg::*;

   state_t              state_q;
   logic [RIDX_W-1:0]   cnt_q;
   logic [KW-1:0]       work_q;
   logic [KW-1:0]       work_d;
   logic [KW-1:0]       store_q [0:NR];
   logic [KW-1:0]       rd_key_q;
   logic [KW-1:0]       rd_key_d;
   logic                rd_valid_q;
   logic                busy_q;
   logic                key_ready_q;

   aes_word             rot_w;
   aes_word             sub_w;
   aes_word             temp_w;
   aes_word             n0, n1, n2, n3;

   assign rot_w = {work_q[23:0], work_q[31:24]};

   aes_sbox u_sbox0 (.in_i(rot_w[31:24]), .out_o(sub_w[31:24]));
   aes_sbox u_sbox1 (.in_i(rot_w[23:16]), .out_o(sub_w[23:16]));
   aes_sbox u_sbox2 (.in_i(rot_w[15:8]),  .out_o(sub_w[15:8]));
   aes_sbox u_sbox3 (.in_i(rot_w[7:0]),   .out_o(sub_w[7:0]));

   // Next round key from the working key and the current round's Rcon.
   always_comb begin
      temp_w = sub_w ^ {rcon(cnt_q), 24'h0};
      n0     = work_q[127:96] ^ temp_w;
      n1     = work_q[95:64]  ^ n0;
      n2     = work_q[63:32]  ^ n1;
      n3     = work_q[31:0]   ^ n2;
      work_d = {n0, n1, n2, n3};
   end

   // Read data: stored key only when the whole schedule is valid and the
   // index is in range; otherwise the all-zero "no key" value.
   always_comb begin
      rd_key_d = '0;
      if (key_ready_q && (rd_round <= 4'(NR))) begin
         rd_key_d = store_q[rd_round];
      end
   end

   // Key store: round 0 on load, rounds 1..NR during generation.
   always_ff @(posedge clk) begin
      if (key_load) begin
         store_q[0] <= key_in;
      end else if ((state_q == GEN) && (cnt_q <= 4'(NR))) begin
         store_q[cnt_q] <= work_d;
      end
   end

   // Control FSM with registered status and read-port outputs; the read
   // uses the pre-edge key_ready so a same-cycle load serves the old store.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         busy_q      <= 1'b0;
         key_ready_q <= 1'b0;
         rd_key_q    <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_key_q   <= rd_key_d;
            rd_valid_q <= 1'b1;
         end else begin
            rd_valid_q <= 1'b0;
         end

         if (key_load) begin
            state_q     <= GEN;
            work_q      <= key_in;
            cnt_q       <= 4'd1;
            busy_q      <= 1'b1;
            key_ready_q <= 1'b0;
         end else begin
            case (state_q)
               GEN: begin
                  work_q <= work_d;
                  cnt_q  <= cnt_q + 4'd1;
                  if (cnt_q == 4'(NR)) begin
                     state_q     <= READY;
                     busy_q      <= 1'b0;
                     key_ready_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

   assign rd_key    = rd_key_q;
   assign rd_valid  = rd_valid_q;
   assign busy      = busy_q;
   assign key_ready = key_ready_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key schedule vectors.
module tb_aes_key_expand;

   logic         clk;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic         rd_en;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;
   logic         rd_valid;
   logic         busy;
   logic         key_ready;

   int unsigned  n_chk;
   int unsigned  n_fail;

   logic [127:0] ka [0:10];
   logic [127:0] kb0;
   logic [127:0] kb10;

   aes_key_expand #(.NR(10), .KW(128)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_load  (key_load),
      .rd_en     (rd_en),
      .rd_round  (rd_round),
      .rd_key    (rd_key),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .key_ready (key_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
      ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      kb0    = 128'h000102030405060708090a0b0c0d0e0f;
      kb10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

      rst      = 1'b1;
      key_in   = '0;
      key_load = 1'b0;
      rd_en    = 1'b0;
      rd_round = '0;
      tick();
      tick();
      chk("rst_rd_key", rd_key, '0);
      chk1("rst_rd_valid", rd_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_key_ready", key_ready, 1'b0);
      rst = 1'b0;
      tick();

      // Read before any key exists.
      rd_en = 1'b1;
      rd_round = 4'd0;
      tick();
      chk("idle_rd_key", rd_key, '0);
      chk1("idle_rd_valid", rd_valid, 1'b1);

      // Load key A; key_ready rises 11 cycles after the pulse cycle.
      key_in = ka[0];
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk1("gen_busy_first", busy, 1'b1);
      chk1("gen_ready_first", key_ready, 1'b0);
      for (int i = 2; i <= 10; i++) begin
         if (i == 10) rd_en = 1'b0;
         tick();
         chk1("gen_busy", busy, 1'b1);
         chk1("gen_ready_low", key_ready, 1'b0);
         chk("gen_rd_zero", rd_key, '0);
      end
      tick();
      chk1("done_ready", key_ready, 1'b1);
      chk1("done_busy", busy, 1'b0);
      chk1("done_rd_valid_low", rd_valid, 1'b0);

      // Back-to-back reads of all rounds.
      rd_en = 1'b1;
      for (int r = 0; r <= 10; r++) begin
         rd_round = 4'(r);
         tick();
         chk($sformatf("rd_round%0d", r), rd_key, ka[r]);
         chk1("rd_valid_b2b", rd_valid, 1'b1);
      end
      rd_en = 1'b0;
      tick();
      chk1("rd_idle_valid", rd_valid, 1'b0);
      chk("rd_hold", rd_key, ka[10]);

      // Out-of-range rounds.
      rd_en = 1'b1;
      rd_round = 4'd11;
      tick();
      chk("rd_r11", rd_key, '0);
      chk1("rd_r11_valid", rd_valid, 1'b1);
      rd_round = 4'd15;
      tick();
      chk("rd_r15", rd_key, '0);
      chk1("rd_r15_valid", rd_valid, 1'b1);

      // Reload A together with a round-10 read: old store serves the read.
      rd_round = 4'd10;
      key_in = ka[0];
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      rd_en = 1'b0;
      chk("load_rd_old_r10", rd_key, ka[10]);
      chk1("load_ready_drop", key_ready, 1'b0);
      chk1("load_busy", busy, 1'b1);

      // Restart mid-generation with key B.
      for (int i = 0; i < 4; i++) tick();
      key_in = kb0;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      for (int i = 2; i <= 10; i++) begin
         tick();
         chk1("restart_no_pulse", key_ready, 1'b0);
      end
      tick();
      chk1("restart_ready", key_ready, 1'b1);
      rd_en = 1'b1;
      rd_round = 4'd10;
      tick();
      chk("restart_r10", rd_key, kb10);
      rd_round = 4'd0;
      tick();
      chk("restart_r0", rd_key, kb0);
      rd_en = 1'b0;

      // Asynchronous reset in the middle of generation.
      key_in = ka[0];
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      tick();
      tick();
      chk("pre_rst_hold", rd_key, kb0);
      rd_en = 1'b1;
      #3 rst = 1'b1;
      #1;
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_ready", key_ready, 1'b0);
      chk1("arst_rd_valid", rd_valid, 1'b0);
      chk("arst_rd_key", rd_key, '0);
      #2 rst = 1'b0;
      rd_round = 4'd0;
      tick();
      chk("post_rst_rd", rd_key, '0);
      chk1("post_rst_valid", rd_valid, 1'b1);
      rd_en = 1'b0;

      // Fresh load after reset.
      key_in = kb0;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk1("fresh_ready", key_ready, 1'b1);
      rd_en = 1'b1;
      rd_round = 4'd10;
      tick();
      chk("fresh_r10", rd_key, kb10);
      rd_en = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- AES-128 key schedule engine, directly upstream of the round-key XOR stage.
- Takes a 128-bit cipher key and iteratively generates round keys 0..10, one per clock, into an internal 11-entry store.
- Serves round keys by round index through a registered read port. The read index is the same round number the XOR stage uses, so the output drives its key input directly.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported).
- KW, 128, key / round-key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  128  cipher key; byte 0 = bits [127:120].
- key_load  input  1  one-cycle pulse; captures key_in and starts expansion.
- rd_en  input  1  read request for rd_round.
- rd_round  input  4  round index to read, 0..10.
- rd_key  output  128  registered round key for the last accepted read.
- rd_valid  output  1  rd_key is valid this cycle.
- busy  output  1  expansion in progress.
- key_ready  output  1  all 11 round keys valid in the store.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - rd_key=0, rd_valid=0, busy=0, key_ready=0.
  - Round counter = 0.
  - Key store contents are don't-care but marked invalid.
- States: IDLE, GEN, READY.
- IDLE:
  - key_load=1 at edge: store[0] <= key_in, working key <= key_in, counter <= 1, go to GEN.
  - busy=1 from the next cycle.
- GEN: each cycle computes round key r = counter from the working key w0..w3 (w0 = bits [127:96]):
  - temp = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - n0 = w0^temp, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - store[r] and the working key are updated at the same edge; counter increments.
  - After writing r=10, go to READY: busy=0 and key_ready=1 in the same cycle.
  - Total latency: key_load edge to key_ready high = 11 cycles.
- READY: holds until the next key_load, which behaves as in IDLE.
  - key_ready drops to 0 in the cycle after the key_load edge.
- key_load during GEN:
  - Aborts the current expansion and restarts with the new key_in (counter=1, store[0] rewritten).
  - No partial key_ready pulse is produced.
- Read port, 1-cycle latency:
  - rd_en=1 at edge N gives rd_key/rd_valid at N+1.
  - Read with key_ready=1 and rd_round<=10: rd_key=store[rd_round], rd_valid=1.
  - Read with key_ready=0 (IDLE/GEN) or rd_round>10: rd_key=0, rd_valid=1. An all-zero key is the defined "no key" value, matching downstream zeroing.
  - rd_en=0: rd_valid=0 and rd_key holds its last value.
- Simultaneous key_load and rd_en in READY: the read is served from the old store contents (read precedes invalidation); key_ready falls the following cycle.
- Rcon sequence for r=1..10: 01,02,04,08,10,20,40,80,1b,36.
- SubWord: four parallel S-box lookups, purely combinational within the GEN cycle.

Decomposition:
- Shared package aes_pkg:
  - round-index width (4), NR, KW constants.
  - Rcon table function/constant.
  - state enum {IDLE, GEN, READY}.
  - aes_word (32-bit) typedef.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4x for SubWord.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, key_load pulse:
  - key_ready high exactly 11 cycles later, busy high in between.
  - Read round 0 -> 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 1 -> a0fafe1788542cb123a339392a6c7605.
  - Round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read rounds 0..10 back-to-back with rd_en held high: one valid key per cycle, each 1 cycle after its request, all 11 matching FIPS-197 A.1.
- rd_round=11 and rd_round=15 while READY: rd_valid=1, rd_key=0. Read while busy: rd_key=0.
- Restart: load key A, then at cycle 5 of GEN load key 000102030405060708090a0b0c0d0e0f. key_ready rises 11 cycles after the second load; round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Assert rst asynchronously mid-GEN (between edges): busy, key_ready, rd_valid and rd_key go 0 immediately. A post-reset read returns 0 until a fresh load completes.
- key_load and rd_en(round 10) in the same cycle while READY: rd_key returns the old key's round 10 value; key_ready=0 the next cycle.
